// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit-opcode CPU.
// Define MULTICYCLE_SEQ_PERF_EN to add the retired/stallCycles performance counters.
module multicycle_seq #(
    parameter logic [3:0]  HALT_OP     = 4'b0000,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrt,
    input  logic        branchZero,
    input  logic        branchNeg,
    input  logic        jump,
    input  logic        jumpMem,
    input  logic        zeroFlag,
    input  logic        negFlag,
    input  logic        imemReady,
    input  logic        dmemReady,
    output logic        imemReq,
    output logic        irWrite,
    output logic        dmemRead,
    output logic        dmemWrite,
    output logic        regWrtEn,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic [2:0]  state,
`ifdef MULTICYCLE_SEQ_PERF_EN
    output logic [31:0] retired,
    output logic [31:0] stallCycles,
`endif
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_wrt;
        logic branch_zero;
        logic branch_neg;
        logic jump;
        logic jump_mem;
    } ctl_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    ctl_t            ctl_q, ctl_d;
    logic            taken_q, taken_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0] cnt_inc;
    logic            wait_expired;

    // Saturating wait counter; the cycle that would reach MEM_TIMEOUT faults instead.
    assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);
    assign wait_expired = (cnt_q >= TO_LAST);
    assign state        = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctl_d     = ctl_q;
        taken_d   = taken_q;
        cnt_d     = '0;
        imemReq   = 1'b0;
        irWrite   = 1'b0;
        dmemRead  = 1'b0;
        dmemWrite = 1'b0;
        regWrtEn  = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 2'd0;
        halted    = 1'b0;
        fault     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imemReq = 1'b1;
                irWrite = imemReady;
                if (imemReady) begin
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (wait_expired) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ctl_d = '{mem_read: memRead, mem_write: memWrite, reg_wrt: regWrt,
                          branch_zero: branchZero, branch_neg: branchNeg,
                          jump: jump, jump_mem: jumpMem};
                if (opcode == HALT_OP)          state_d = S_HALT;
                else if (memRead && memWrite)   state_d = S_FAULT;
                else                            state_d = S_EXEC;
            end
            S_EXEC: begin
                taken_d = ctl_q.jump | (ctl_q.branch_zero & zeroFlag) | (ctl_q.branch_neg & negFlag);
                if (ctl_q.mem_read || ctl_q.mem_write || ctl_q.jump_mem) state_d = S_MEM;
                else                                                     state_d = S_WB;
            end
            S_MEM: begin
                dmemRead  = ctl_q.mem_read | ctl_q.jump_mem;
                dmemWrite = ctl_q.mem_write;
                if (dmemReady) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (wait_expired) state_d = S_FAULT;
                end
            end
            S_WB: begin
                regWrtEn = ctl_q.reg_wrt;
                pcWrite  = 1'b1;
                if (ctl_q.jump_mem) pcSrc = 2'd2;
                else if (taken_q)   pcSrc = 2'd1;
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULTICYCLE_SEQ_PERF_EN
    // Retired instructions and cycles lost waiting on either memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired     <= '0;
            stallCycles <= '0;
        end else begin
            if (state_q == S_WB) retired <= retired + 32'd1;
            if ((state_q == S_FETCH && !imemReady) || (state_q == S_MEM && !dmemReady))
                stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Testbench for multicycle_seq: table vectors, corner sequences and random instructions
// checked cycle by cycle against an instruction-level trace model.
`timescale 1ns/1ps
module tb_multicycle_seq;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_FAULT = 3'd7;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic [3:0]  opcode;
    logic        memRead, memWrite, regWrt, branchZero, branchNeg, jump, jumpMem;
    logic        zeroFlag, negFlag, imemReady, dmemReady;
    logic        imemReq, irWrite, dmemRead, dmemWrite, regWrtEn, pcWrite, halted, fault;
    logic [1:0]  pcSrc;
    logic [2:0]  state;
`ifdef MULTICYCLE_SEQ_PERF_EN
    logic [31:0] retired, stallCycles;
`endif

    always #5 clk = ~clk;

    multicycle_seq dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .memRead(memRead), .memWrite(memWrite), .regWrt(regWrt),
        .branchZero(branchZero), .branchNeg(branchNeg), .jump(jump), .jumpMem(jumpMem),
        .zeroFlag(zeroFlag), .negFlag(negFlag), .imemReady(imemReady), .dmemReady(dmemReady),
        .imemReq(imemReq), .irWrite(irWrite), .dmemRead(dmemRead), .dmemWrite(dmemWrite),
        .regWrtEn(regWrtEn), .pcWrite(pcWrite), .pcSrc(pcSrc), .state(state),
`ifdef MULTICYCLE_SEQ_PERF_EN
        .retired(retired), .stallCycles(stallCycles),
`endif
        .halted(halted), .fault(fault)
    );

    // One instruction: decoder bits, flags, and ready delays (>=TMO means never ready).
    typedef struct packed {
        logic [3:0] op;
        logic mr, mw, rw, bz, bn, j, jm, zf, nf;
        logic [4:0] iw, dw;
    } instr_t;
    localparam int IW = $bits(instr_t);

    // One cycle of expected outputs plus the ready inputs to apply.
    typedef struct packed {
        logic [2:0] st;
        logic ireq, irw, drd, dwr, rwe, pcw;
        logic [1:0] psrc;
        logic hlt, flt;
        logic irdy, drdy;
    } cyc_t;

    typedef struct {
        instr_t     in;
        logic [2:0] st;
        logic [1:0] psrc;
        logic       rwe, pcw;
    } vec_t;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_ret = 0, exp_stall = 0;
    cyc_t        trace[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic instr_t mk_in(input logic [3:0] op, input logic mr, mw, rw, bz, bn, j, jm,
                                     zf, nf, input logic [4:0] iw, dw);
        instr_t r;
        r = '{op: op, mr: mr, mw: mw, rw: rw, bz: bz, bn: bn, j: j, jm: jm, zf: zf, nf: nf,
              iw: iw, dw: dw};
        return r;
    endfunction

    function automatic cyc_t obs();
        cyc_t g = '0;
        g.st = state; g.ireq = imemReq; g.irw = irWrite; g.drd = dmemRead; g.dwr = dmemWrite;
        g.rwe = regWrtEn; g.pcw = pcWrite; g.psrc = pcSrc; g.hlt = halted; g.flt = fault;
        return g;
    endfunction

    function automatic void add_terminal(input logic [2:0] st);
        cyc_t c;
        for (int i = 0; i < 4; i++) begin
            c = '0; c.st = st; c.hlt = (st == ST_HALT); c.flt = (st == ST_FAULT);
            trace.push_back(c);
        end
    endfunction

    // Wait phase in FETCH or MEM: w idle cycles then one ready cycle, or TMO idle cycles.
    function automatic bit wait_phase(input logic [2:0] st, input int w, input logic drd, dwr);
        cyc_t c;
        for (int i = 0; i < TMO && i <= w; i++) begin
            c = '0; c.st = st; c.ireq = (st == ST_FETCH); c.drd = drd; c.dwr = dwr;
            if (i == w) begin
                if (st == ST_FETCH) begin c.irdy = 1'b1; c.irw = 1'b1; end
                else c.drdy = 1'b1;
            end
            trace.push_back(c);
        end
        return w >= TMO;
    endfunction

    // Expected cycle-by-cycle trace of one instruction starting in FETCH.
    function automatic void build_trace(input instr_t in);
        cyc_t c;
        logic taken;
        trace.delete();
        if (wait_phase(ST_FETCH, int'(in.iw), 1'b0, 1'b0)) begin add_terminal(ST_FAULT); return; end
        c = '0; c.st = ST_DECODE; trace.push_back(c);
        if (in.op == 4'b0000) begin add_terminal(ST_HALT); return; end
        if (in.mr && in.mw) begin add_terminal(ST_FAULT); return; end
        c = '0; c.st = ST_EXEC; trace.push_back(c);
        if (in.mr || in.mw || in.jm)
            if (wait_phase(ST_MEM, int'(in.dw), in.mr | in.jm, in.mw)) begin
                add_terminal(ST_FAULT); return;
            end
        taken = in.j | (in.bz & in.zf) | (in.bn & in.nf);
        c = '0; c.st = ST_WB; c.rwe = in.rw; c.pcw = 1'b1;
        c.psrc = in.jm ? 2'd2 : (taken ? 2'd1 : 2'd0);
        trace.push_back(c);
    endfunction

    // Apply up to max trace cycles; decoder bits/flags are valid only where the DUT samples them.
    task automatic run_trace(input instr_t in, input int max, output cyc_t last);
        cyc_t e, g;
        int   n;
        n = (max < trace.size()) ? max : trace.size();
        last = '0;
        for (int k = 0; k < n; k++) begin
            e = trace[k];
            run = 1'($urandom);
            {opcode, memRead, memWrite, regWrt, branchZero, branchNeg, jump, jumpMem} = 11'($urandom);
            {zeroFlag, negFlag} = 2'($urandom);
            if (e.st == ST_DECODE)
                {opcode, memRead, memWrite, regWrt, branchZero, branchNeg, jump, jumpMem} =
                    {in.op, in.mr, in.mw, in.rw, in.bz, in.bn, in.j, in.jm};
            if (e.st == ST_EXEC) {zeroFlag, negFlag} = {in.zf, in.nf};
            imemReady = (e.st == ST_FETCH) ? e.irdy : 1'($urandom);
            dmemReady = (e.st == ST_MEM)   ? e.drdy : 1'($urandom);
            if (e.st == ST_WB) exp_ret++;
            if ((e.st == ST_FETCH && !e.irdy) || (e.st == ST_MEM && !e.drdy)) exp_stall++;
            e.irdy = 1'b0; e.drdy = 1'b0;
            #1;
            g = obs();
            check($sformatf("cycle%0d_st%0d", k, e.st), 32'(g), 32'(e));
            last = g;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef MULTICYCLE_SEQ_PERF_EN
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_stall"}, stallCycles, exp_stall);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Async reset, then idle cycles with run=0, then a run pulse into FETCH.
    task automatic restart(input int idle);
        rst_n = 1'b0; run = 1'b0;
        #1;
        check("reset_outputs", 32'(obs()), 32'(0));
        exp_ret = 0; exp_stall = 0;
        check_perf("reset");
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        for (int i = 0; i <= idle; i++) begin
            run = (i == idle);
            {opcode, memRead, memWrite, regWrt, branchZero, branchNeg, jump, jumpMem} = 11'($urandom);
            {zeroFlag, negFlag, imemReady, dmemReady} = 4'($urandom);
            #1;
            check($sformatf("idle%0d", i), 32'(obs()), 32'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t   tbl[14];
        cyc_t   last;
        instr_t in;

        //                 op    mr mw rw bz bn j  jm zf nf iw dw
        tbl[0]  = '{mk_in(4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),  ST_WB,    2'd0, 1, 1};
        tbl[1]  = '{mk_in(4'h1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3),  ST_WB,    2'd0, 1, 1};
        tbl[2]  = '{mk_in(4'h2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1),  ST_WB,    2'd0, 0, 1};
        tbl[3]  = '{mk_in(4'h3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0),  ST_WB,    2'd1, 0, 1};
        tbl[4]  = '{mk_in(4'h3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),  ST_WB,    2'd0, 0, 1};
        tbl[5]  = '{mk_in(4'h4, 0, 0, 1, 0, 1, 0, 0, 0, 1, 2, 0),  ST_WB,    2'd1, 1, 1};
        tbl[6]  = '{mk_in(4'h6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),  ST_WB,    2'd1, 0, 1};
        tbl[7]  = '{mk_in(4'h7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2),  ST_WB,    2'd2, 0, 1};
        tbl[8]  = '{mk_in(4'h8, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0),  ST_WB,    2'd2, 0, 1};
        tbl[9]  = '{mk_in(4'h9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 14, 0), ST_WB,    2'd0, 1, 1};
        tbl[10] = '{mk_in(4'h0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),  ST_HALT,  2'd0, 0, 0};
        tbl[11] = '{mk_in(4'hA, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0),  ST_FAULT, 2'd0, 0, 0};
        tbl[12] = '{mk_in(4'hB, 0, 0, 1, 0, 0, 0, 0, 0, 0, 15, 0), ST_FAULT, 2'd0, 0, 0};
        tbl[13] = '{mk_in(4'hC, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 15), ST_FAULT, 2'd0, 0, 0};

        restart(10);
        for (int i = 0; i < 14; i++) begin
            build_trace(tbl[i].in);
            run_trace(tbl[i].in, 1000, last);
            check($sformatf("vec%0d_state", i), 32'(last.st), 32'(tbl[i].st));
            check($sformatf("vec%0d_pcsrc", i), 32'(last.psrc), 32'(tbl[i].psrc));
            check($sformatf("vec%0d_regwrten", i), 32'(last.rwe), 32'(tbl[i].rwe));
            check($sformatf("vec%0d_pcwrite", i), 32'(last.pcw), 32'(tbl[i].pcw));
            check_perf($sformatf("vec%0d", i));
            if (tbl[i].st != ST_WB) restart(0);
        end

        // Reset asserted mid-MEM: strobes drop immediately, no writeback.
        in = mk_in(4'h1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        build_trace(in);
        run_trace(in, 5, last);
        dmemReady = 1'b0;
        #1;
        check("midmem_dmemread_before", 32'(dmemRead), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midmem_dmemread_after", 32'(dmemRead), 32'(0));
        check("midmem_state_after", 32'(state), 32'(ST_IDLE));
        check("midmem_writes_after", 32'({regWrtEn, pcWrite}), 32'(0));
        restart(0);

        // Random instruction stream.
        for (int r = 0; r < 80; r++) begin
            in = instr_t'(IW'($urandom));
            in.iw = ($urandom_range(0, 11) == 0) ? 5'(15 + $urandom_range(0, 3)) : 5'($urandom_range(0, 3));
            in.dw = ($urandom_range(0, 11) == 0) ? 5'(15 + $urandom_range(0, 3)) : 5'($urandom_range(0, 3));
            if (in.op == 4'b0000 && $urandom_range(0, 3) != 0) in.op = 4'h5;
            if (in.mr && in.mw && $urandom_range(0, 3) != 0) in.mw = 1'b0;
            build_trace(in);
            run_trace(in, 1000, last);
            check_perf($sformatf("rnd%0d", r));
            if (trace[trace.size() - 1].st != ST_WB) restart(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multicycle instruction sequencer for the 4-bit-opcode CPU.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Registers the opcode decoder's control bits at DECODE, then generates the per-cycle enables: PC write, IR write, register write, and memory strobes.
- Handles the ready handshakes with instruction and data memory, a memory timeout, and halt.

Parameters:
- HALT_OP, 4'b0000, opcode that sends the sequencer to HALT.
- MEM_TIMEOUT, 15, maximum wait cycles for imemReady/dmemReady before FAULT (1..255).
- TO_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  leave IDLE and start fetching.
- opcode  in  4  IR[opcode] as seen by the decoder.
- memRead, memWrite, regWrt, branchZero, branchNeg, jump, jumpMem  in  1 each  decoder outputs.
- zeroFlag, negFlag  in  1 each  ALU flags.
- imemReady  in  1  instruction memory data valid.
- dmemReady  in  1  data memory access complete.
- imemReq  out  1  instruction fetch request.
- irWrite  out  1  load IR.
- dmemRead, dmemWrite  out  1 each  data memory strobes.
- regWrtEn  out  1  register file write enable.
- pcWrite  out  1  PC update.
- pcSrc  out  2  0=PC+1, 1=branch target, 2=memory data.
- state  out  3  current state encoding.
- halted  out  1  in HALT.
- fault  out  1  in FAULT.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0; pcSrc=0.
  - Latched controls, taken flag and wait counter cleared.
  - Reset mid-instruction aborts the instruction with no PC or register write.
- All outputs are Moore outputs decoded from state and registered controls, except irWrite (see FETCH).
- IDLE: run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imemReq=1.
  - irWrite=imemReady in the same cycle.
  - imemReady=1 -> DECODE, wait counter cleared.
  - Else counter +1; at counter==MEM_TIMEOUT -> FAULT.
- DECODE:
  - Latch all decoder bits.
  - opcode==HALT_OP -> HALT.
  - memRead&memWrite both 1 -> FAULT.
  - Else -> EXEC.
- EXEC:
  - Sample flags: taken = jump | (branchZero&zeroFlag) | (branchNeg&negFlag).
  - Any of memRead|memWrite|jumpMem -> MEM; else -> WB.
- MEM:
  - dmemRead = memRead|jumpMem; dmemWrite = memWrite; held until dmemReady.
  - dmemReady=1 -> WB.
  - Timeout rule as in FETCH -> FAULT.
- WB (one cycle, then FETCH):
  - regWrtEn = latched regWrt.
  - pcWrite=1.
  - pcSrc = 2 if jumpMem, else 1 if taken, else 0.
- Min latency: 4 cycles for ALU op, 5 for memory op (ready returned the first cycle).
- HALT, FAULT:
  - Terminal; only rst_n exits.
  - halted/fault=1; all strobes 0.
  - run is ignored.
- run deasserted mid-instruction has no effect; the sequencer returns to FETCH, not IDLE, after WB.
- Wait counter saturates; never wraps.

Optional Feature:
- Macro MULTICYCLE_SEQ_PERF_EN.
- Defined:
  - Adds outputs retired[31:0] and stallCycles[31:0].
  - retired increments on every WB cycle.
  - stallCycles increments each FETCH/MEM cycle with ready=0.
  - Both cleared by reset; wrap modulo 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset with run=0 -> state=0, all outputs 0 for 10 cycles; run=1 with opcode=4'b1111, regWrt=1, imemReady=1 -> states 1,2,3,5; regWrtEn=1 and pcWrite=1, pcSrc=0 in cycle 4; back to FETCH.
- Load (memRead=1, regWrt=1), dmemReady delayed 3 cycles -> dmemRead held 4 cycles, then WB with regWrtEn=1.
- branchZero=1 with zeroFlag=1 -> pcSrc=1; same instruction with zeroFlag=0 -> pcSrc=0; jumpMem=1 -> MEM with dmemRead=1, then pcSrc=2.
- imemReady held 0 -> FAULT after exactly 15 wait cycles, fault=1; run toggling ignored; rst_n pulse -> IDLE.
- opcode=HALT_OP -> HALT after DECODE, no pcWrite; memRead=memWrite=1 -> FAULT.
- rst_n asserted during MEM -> dmemRead drops immediately, state=0; with MULTICYCLE_SEQ_PERF_EN, 3 instructions -> retired=3, stallCycles equals injected wait count.
